// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the ID-stage pipeline and the hazard/stall controller.
// Level-sensitive enables, not a valid/ready handshake: each output is valid for the cycle's inputs.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs2;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;
    logic             mem_busy;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_bubble;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic [1:0]       dbg_state;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd, ex_branch_taken, mem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
        input  stall_count, flush_count, dbg_state
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd, ex_branch_taken, mem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
        output stall_count, flush_count, dbg_state
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall, taken-branch flush and memory-wait freeze control for IF/ID and ID/EX.
// Outputs are Mealy so every stall or flush acts in the cycle it is detected.
module hazard_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic               clk,
    input  logic               reset,
    hazard_stall_ctrl_if.slave ctl
);
    localparam logic [1:0]       RUN       = 2'd0;
    localparam logic [1:0]       FLUSH     = 2'd1;
    localparam logic [1:0]       MEM_WAIT  = 2'd2;
    localparam logic [3:0]       FC_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [1:0]       state, state_nxt, eff_state;
    logic [3:0]       fcnt, fcnt_nxt;
    logic             resume, resume_nxt;
    logic             load_use, stall_inc, flush_inc;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    assign load_use = ctl.ex_mem_read && (ctl.ex_rd != 5'd0) &&
                      ((ctl.ex_rd == ctl.id_rs1) ||
                       (ctl.id_uses_rs2 && (ctl.ex_rd == ctl.id_rs2)));

    // A frozen cycle resumes whichever of RUN or FLUSH it interrupted.
    assign eff_state = (state == MEM_WAIT) ? (resume ? FLUSH : RUN) : state;

    always_comb begin
        state_nxt        = eff_state;
        fcnt_nxt         = fcnt;
        resume_nxt       = 1'b0;
        stall_inc        = 1'b0;
        flush_inc        = 1'b0;
        ctl.pc_write     = 1'b1;
        ctl.if_id_write  = 1'b1;
        ctl.if_id_flush  = 1'b0;
        ctl.id_ex_write  = 1'b1;
        ctl.id_ex_bubble = 1'b0;
        if (ctl.mem_busy) begin
            ctl.pc_write    = 1'b0;
            ctl.if_id_write = 1'b0;
            ctl.id_ex_write = 1'b0;
            state_nxt       = MEM_WAIT;
            resume_nxt      = (eff_state == FLUSH);
            stall_inc       = 1'b1;
        end else if (ctl.ex_branch_taken) begin
            ctl.if_id_flush  = 1'b1;
            ctl.id_ex_bubble = 1'b1;
            flush_inc        = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                fcnt_nxt  = FC_RELOAD;
            end else begin
                state_nxt = RUN;
                fcnt_nxt  = 4'd0;
            end
        end else if (eff_state == FLUSH) begin
            ctl.if_id_flush  = 1'b1;
            ctl.id_ex_bubble = 1'b1;
            if (fcnt <= 4'd1) begin
                state_nxt = RUN;
                fcnt_nxt  = 4'd0;
            end else begin
                fcnt_nxt = fcnt - 4'd1;
            end
        end else if (load_use) begin
            ctl.pc_write     = 1'b0;
            ctl.if_id_write  = 1'b0;
            ctl.id_ex_bubble = 1'b1;
            stall_inc        = 1'b1;
        end
        if (!reset) begin
            ctl.pc_write     = 1'b0;
            ctl.if_id_write  = 1'b0;
            ctl.id_ex_write  = 1'b0;
            ctl.if_id_flush  = 1'b1;
            ctl.id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            fcnt      <= 4'd0;
            resume    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state  <= state_nxt;
            fcnt   <= fcnt_nxt;
            resume <= resume_nxt;
            if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign ctl.stall_count = stall_cnt;
    assign ctl.flush_count = flush_cnt;
    assign ctl.dbg_state   = state;
endmodule
